ones_mod_detect: RTL and testbench

ONES_MOD_DETECT -- requirements
Module: ones_mod_detect

---
 rtl/ones_mod_pkg.sv | 24 ++
 rtl/popcount.sv | 22 ++
 rtl/ones_mod_detect.sv | 108 ++++++++++
 tb/tb_ones_mod_detect.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/ones_mod_pkg.sv
// ones_mod_pkg
//   Shared constants and helpers for the ones_mod_detect block.
//   - Default parameter values used by the top module.
//   - clamp_mod(): maps a requested modulus onto the supported range 1..maxmod.
package ones_mod_pkg;

  localparam int W_DEFAULT       = 4;
  localparam int MAXMOD_DEFAULT  = 16;
  localparam int DEF_MOD_DEFAULT = 4;
  localparam int HW_DEFAULT      = 8;

  // A modulus of 0 is meaningless and 1 degenerates to "every beat is a
  // multiple", so both collapse to 1; oversize requests saturate at maxmod.
  function automatic int clamp_mod(input int val, input int maxmod);
    if (val <= 1) begin
      return 1;
    end else if (val > maxmod) begin
      return maxmod;
    end else begin
      return val;
    end
  endfunction

endpackage

// File: rtl/popcount.sv
// popcount
//   Counts the number of set bits in a W-bit word (purely combinational).
//   Ports:
//     din : input  [W-1:0]             word to count
//     pop : output [$clog2(W+1)-1:0]   number of 1s in din, 0..W
module popcount #(
  parameter int W = 4
) (
  input  logic [W-1:0]             din,
  output logic [$clog2(W+1)-1:0]   pop
);

  localparam int PW = $clog2(W + 1);

  always_comb begin
    pop = '0;
    for (int i = 0; i < W; i++) begin
      pop = pop + PW'(din[i]);
    end
  end

endmodule

// File: rtl/ones_mod_detect.sv
// ones_mod_detect
//   Accumulates the number of 1s seen on din (when en=1) modulo a run-time
//   programmable modulus and flags when the running count is a multiple.
//   Ports:
//     clk     : input             rising-edge clock
//     rst     : input             asynchronous active-high reset
//     en      : input             din valid this cycle
//     din     : input  [W-1:0]    bits whose 1s are accumulated
//     load    : input             load mod_val as the new modulus (din ignored)
//     mod_val : input  [MW-1:0]   requested modulus (clamped to 1..MAXMOD)
//     residue : output [MW-1:0]   registered running count mod modulus
//     y_moore : output            registered, residue == 0
//     y_mealy : output            combinational, this beat lands on a multiple
//     hits    : output [HW-1:0]   registered count of beats landing on a multiple
module ones_mod_detect
  import ones_mod_pkg::*;
#(
  parameter int W       = W_DEFAULT,
  parameter int MAXMOD  = MAXMOD_DEFAULT,
  parameter int DEF_MOD = DEF_MOD_DEFAULT,
  parameter int HW      = HW_DEFAULT,
  localparam int MW     = $clog2(MAXMOD + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [W-1:0]  din,
  input  logic          load,
  input  logic [MW-1:0] mod_val,
  output logic [MW-1:0] residue,
  output logic          y_moore,
  output logic          y_mealy,
  output logic [HW-1:0] hits
);

  localparam int PW = $clog2(W + 1);
  // Wide enough for residue (<= MAXMOD-1) plus pop (<= W) without overflow.
  localparam int SW = $clog2(MAXMOD + W + 1);

  logic [PW-1:0] pop;
  logic [MW-1:0] modulus;
  logic [MW-1:0] mod_clamped;
  logic [SW-1:0] sum;
  logic [MW-1:0] acc_res;
  logic          acc_zero;
  logic [MW-1:0] residue_nxt;
  logic [MW-1:0] modulus_nxt;
  logic [HW-1:0] hits_nxt;

  popcount #(.W(W)) u_popcount (
    .din (din),
    .pop (pop)
  );

  assign mod_clamped = MW'(clamp_mod(int'(mod_val), MAXMOD));

  // pop may exceed the modulus (e.g. W=4, m=3), so a single conditional
  // subtract is not enough; a true remainder is taken. modulus is never 0.
  always_comb begin
    sum      = SW'(residue) + SW'(pop);
    acc_res  = MW'(sum % SW'(modulus));
    acc_zero = (acc_res == '0);
  end

  always_comb begin
    residue_nxt = residue;
    modulus_nxt = modulus;
    hits_nxt    = hits;
    if (load) begin
      residue_nxt = '0;
      modulus_nxt = mod_clamped;
      hits_nxt    = '0;
    end else if (en) begin
      residue_nxt = acc_res;
      if (acc_zero) begin
        hits_nxt = hits + HW'(1);
      end
    end
  end

  assign y_mealy = en && !load && !rst && acc_zero;
  assign y_moore = (residue == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      residue <= '0;
    end else begin
      residue <= residue_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      modulus <= MW'(DEF_MOD);
    end else begin
      modulus <= modulus_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hits <= '0;
    end else begin
      hits <= hits_nxt;
    end
  end

endmodule

// File: tb/tb_ones_mod_detect.sv
module tb_ones_mod_detect;

  localparam int W      = 4;
  localparam int MAXMOD = 16;
  localparam int MW     = $clog2(MAXMOD + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [W-1:0]  din;
  logic          load;
  logic [MW-1:0] mod_val;
  logic [MW-1:0] residue;
  logic          y_moore;
  logic          y_mealy;
  logic [7:0]    hits;
  logic [MW-1:0] residue2;
  logic          y_moore2;
  logic          y_mealy2;
  logic [1:0]    hits2;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: count of 1s accepted since the last load/reset,
  // current modulus, and number of beats that landed on a multiple.
  int ones_total;
  int m_mod;
  int m_hits;

  always #5 clk = ~clk;

  ones_mod_detect #(.W(W), .MAXMOD(MAXMOD), .DEF_MOD(4), .HW(8)) dut (
    .clk(clk), .rst(rst), .en(en), .din(din), .load(load), .mod_val(mod_val),
    .residue(residue), .y_moore(y_moore), .y_mealy(y_mealy), .hits(hits)
  );

  ones_mod_detect #(.W(W), .MAXMOD(MAXMOD), .DEF_MOD(4), .HW(2)) dut_hw2 (
    .clk(clk), .rst(rst), .en(en), .din(din), .load(load), .mod_val(mod_val),
    .residue(residue2), .y_moore(y_moore2), .y_mealy(y_mealy2), .hits(hits2)
  );

  task automatic chk(input string tag, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic int clamp_ref(input int v);
    if (v < 2) return 1;
    if (v > MAXMOD) return MAXMOD;
    return v;
  endfunction

  task automatic model_reset();
    ones_total = 0;
    m_mod      = 4;
    m_hits     = 0;
  endtask

  task automatic check_regs(input string tag);
    chk({tag, ".residue"}, int'(residue), ones_total % m_mod);
    chk({tag, ".y_moore"}, int'(y_moore), int'((ones_total % m_mod) == 0));
    chk({tag, ".hits"},    int'(hits),    m_hits % 256);
    chk({tag, ".hits2"},   int'(hits2),   m_hits % 4);
  endtask

  // Called just after a rising edge: drives one beat, checks the Mealy
  // output mid-cycle, then advances the model and checks registered state.
  task automatic beat(input string tag, input logic e, input logic [W-1:0] d,
                      input logic l, input logic [MW-1:0] mv);
    int p;
    en = e; din = d; load = l; mod_val = mv;
    p = $countones(d);
    #3;
    chk({tag, ".y_mealy"}, int'(y_mealy),
        int'(e && !l && (((ones_total + p) % m_mod) == 0)));
    @(posedge clk);
    if (l) begin
      m_mod = clamp_ref(int'(mv));
      ones_total = 0;
      m_hits = 0;
    end else if (e) begin
      ones_total += p;
      if (ones_total % m_mod == 0) m_hits++;
    end
    #1;
    check_regs(tag);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; din = '0; load = 1'b0; mod_val = '0;
    model_reset();
    #3;
    check_regs("reset");
    chk("reset.y_mealy", int'(y_mealy), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single 1 per beat at modulus 4.
    for (int i = 0; i < 8; i++) beat("ones1", 1'b1, 4'b0001, 1'b0, '0);
    chk("ones1.final_hits", int'(hits), 2);

    // Full words at modulus 4: every beat is a multiple; HW=2 copy wraps.
    beat("reload4", 1'b0, '0, 1'b1, MW'(4));
    for (int i = 0; i < 5; i++) beat("full4", 1'b1, 4'b1111, 1'b0, '0);
    chk("full4.hits", int'(hits), 5);
    chk("full4.hits2_wrap", int'(hits2), 1);

    // Modulus 3 with pop >= m.
    beat("load3", 1'b0, '0, 1'b1, MW'(3));
    beat("m3a", 1'b1, 4'b0111, 1'b0, '0);
    beat("m3b", 1'b1, 4'b0011, 1'b0, '0);
    beat("m3c", 1'b1, 4'b0011, 1'b0, '0);
    chk("m3.residue", int'(residue), 1);

    // Clamp edges; din ignored in the load cycle.
    beat("load0", 1'b1, 4'b1111, 1'b1, MW'(0));
    for (int i = 0; i < 3; i++) beat("mod1", 1'b1, W'($urandom), 1'b0, '0);
    chk("mod1.y_moore", int'(y_moore), 1);
    beat("load31", 1'b1, 4'b1111, 1'b1, MW'(31));
    for (int i = 0; i < 4; i++) beat("mod16", 1'b1, 4'b1111, 1'b0, '0);
    chk("mod16.residue", int'(residue), 0);

    // Hold with en=0, then asynchronous reset mid-cycle.
    beat("load4b", 1'b0, '0, 1'b1, MW'(4));
    beat("to3", 1'b1, 4'b0111, 1'b0, '0);
    for (int i = 0; i < 3; i++) beat("hold", 1'b0, 4'b1111, 1'b0, '0);
    chk("hold.residue", int'(residue), 3);
    en = 1'b1; din = 4'b0001;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_regs("async_rst");
    chk("async_rst.y_mealy", int'(y_mealy), 0);
    #2;
    rst = 1'b0;
    en = 1'b0;
    @(posedge clk); #1;
    check_regs("post_rst");

    // Randomized traffic with occasional modulus changes.
    for (int i = 0; i < 300; i++) begin
      logic l;
      l = ($urandom_range(0, 19) == 0);
      beat("rand", 1'($urandom), W'($urandom), l, MW'($urandom_range(0, 31)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
